// File: rtl/bitblade_pass_ctrl.sv
// bitblade_pass_ctrl: sequences one dot product into 2-bit chunk-pair
// passes (or one XNOR pass) for the BitBlade PE array.
// Ports:
//   clk, rst (sync, active high)
//   start, cfg_* : job request and config, latched when accepted
//   elem_valid / elem_req : operand fetch handshake
//   pe_bin, pe_sign_i, pe_sign_w, i_sel, w_sel, shift_amt : PE controls
//   acc_clr, acc_en, acc_last : accumulator strobes
//   result_valid / result_ready : result handshake, busy : job active
module bitblade_pass_ctrl #(
  parameter int LEN_W = 16,
  parameter int SH_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       cfg_iprec,
  input  logic [1:0]       cfg_wprec,
  input  logic             cfg_isigned,
  input  logic             cfg_wsigned,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             elem_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             elem_req,
  output logic             pe_bin,
  output logic             pe_sign_i,
  output logic             pe_sign_w,
  output logic [1:0]       i_sel,
  output logic [1:0]       w_sel,
  output logic [SH_W-1:0]  shift_amt,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             acc_last,
  output logic             result_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             bin_q, bin_d;
  logic             isg_q, isg_d;
  logic             wsg_q, wsg_d;
  logic [1:0]       ni_m1_q, ni_m1_d;
  logic [1:0]       nw_m1_q, nw_m1_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       i_q, i_d;
  logic [1:0]       w_q, w_d;
  logic             busy_q, busy_d;
  logic             pe_bin_q, pe_bin_d;
  logic             si_q, si_d;
  logic             sw_q, sw_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  logic             clr_q, clr_d;
  logic             rv_q, rv_d;

  logic             run;
  logic             elem_last;
  logic             last_i;
  logic             last_w;
  logic             job_last;
  logic             active;
  logic             chunked;

  // Index of the most significant 2-bit chunk for a precision code.
  function automatic logic [1:0] top_chunk(input logic [1:0] prec);
    logic [1:0] r;
    case (prec)
      2'b10:   r = 2'd1;
      2'b11:   r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  assign run       = (state_q == S_RUN);
  assign elem_last = (cnt_q == len_q - LEN_W'(1));
  assign last_i    = (i_q == ni_m1_q);
  assign last_w    = (w_q == nw_m1_q);
  assign job_last  = elem_last & last_i & last_w;

  // Enables follow elem_valid directly so the consume strobe and the
  // registered chunk controls land in the same cycle.
  assign elem_req  = run & elem_valid;
  assign acc_en    = run & elem_valid;
  assign acc_last  = run & elem_valid & job_last;

  assign busy         = busy_q;
  assign pe_bin       = pe_bin_q;
  assign pe_sign_i    = si_q;
  assign pe_sign_w    = sw_q;
  assign i_sel        = i_q;
  assign w_sel        = w_q;
  assign shift_amt    = sh_q;
  assign acc_clr      = clr_q;
  assign result_valid = rv_q;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    isg_d   = isg_q;
    wsg_d   = wsg_q;
    ni_m1_d = ni_m1_q;
    nw_m1_d = nw_m1_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    w_d     = w_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          bin_d   = (cfg_iprec == 2'b00);
          isg_d   = cfg_isigned;
          wsg_d   = cfg_wsigned;
          ni_m1_d = top_chunk(cfg_iprec);
          // Binary mode is a single pass regardless of weight width.
          nw_m1_d = (cfg_iprec == 2'b00) ? 2'd0 : top_chunk(cfg_wprec);
          len_d   = cfg_len;
          cnt_d   = '0;
          i_d     = 2'd0;
          w_d     = 2'd0;
        end
      end
      S_CLR: begin
        state_d = (len_q == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (elem_valid) begin
          if (elem_last) begin
            cnt_d = '0;
            if (last_i) begin
              i_d = 2'd0;
              if (last_w) begin
                w_d     = 2'd0;
                state_d = S_DONE;
              end else begin
                w_d = w_q + 2'd1;
              end
            end else begin
              i_d = i_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      S_DONE: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    active   = (state_d != S_IDLE);
    chunked  = active & ~bin_d;
    busy_d   = active;
    clr_d    = (state_d == S_CLR);
    rv_d     = (state_d == S_DONE);
    pe_bin_d = active & bin_d;
    si_d     = chunked & isg_d & (i_d == ni_m1_d);
    sw_d     = chunked & wsg_d & (w_d == nw_m1_d);
    sh_d     = chunked ? SH_W'({i_d, 1'b0}) + SH_W'({w_d, 1'b0})
                       : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bin_q    <= 1'b0;
      isg_q    <= 1'b0;
      wsg_q    <= 1'b0;
      ni_m1_q  <= 2'd0;
      nw_m1_q  <= 2'd0;
      len_q    <= '0;
      cnt_q    <= '0;
      i_q      <= 2'd0;
      w_q      <= 2'd0;
      busy_q   <= 1'b0;
      pe_bin_q <= 1'b0;
      si_q     <= 1'b0;
      sw_q     <= 1'b0;
      sh_q     <= '0;
      clr_q    <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      isg_q    <= isg_d;
      wsg_q    <= wsg_d;
      ni_m1_q  <= ni_m1_d;
      nw_m1_q  <= nw_m1_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      i_q      <= i_d;
      w_q      <= w_d;
      busy_q   <= busy_d;
      pe_bin_q <= pe_bin_d;
      si_q     <= si_d;
      sw_q     <= sw_d;
      sh_q     <= sh_d;
      clr_q    <= clr_d;
      rv_q     <= rv_d;
    end
  end

endmodule
